// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: holds all domain resets for a minimum pulse width, then releases them in
// index order with a stagger; also services level req/ack soft resets. Option: RESET_SEQ_PLL_LOCK_EN.
module reset_seq_ctrl #(
   parameter int unsigned NUM_DOMAINS    = 4,
   parameter int unsigned HOLD_CYCLES    = 16,
   parameter int unsigned STAGGER_CYCLES = 8,
   parameter int unsigned CNT_W          = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   io_sw_req,
   input  logic [NUM_DOMAINS-1:0] io_sw_mask,
   output logic                   io_sw_ack,
`ifdef RESET_SEQ_PLL_LOCK_EN
   input  logic                   io_pll_lock,
`endif
   output logic [NUM_DOMAINS-1:0] io_domain_reset,
   output logic                   io_busy,
   output logic                   io_all_released
);

   localparam int unsigned IDX_W = $clog2(NUM_DOMAINS + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);

   typedef enum logic [2:0] {
      S_HOLD,
      S_WAIT_LOCK,
      S_RELEASE,
      S_IDLE,
      S_ACK
   } state_t;

   state_t                 state, state_n;
   logic [CNT_W-1:0]       cnt, cnt_n;
   logic [IDX_W-1:0]       idx, idx_n;
   logic [NUM_DOMAINS-1:0] mask_r, mask_n;
   logic                   soft_q, soft_n;
   logic [NUM_DOMAINS-1:0] dom_n;
   logic                   busy_n, ack_n, all_rel_n;

   logic                   found;
   logic [NUM_DOMAINS-1:0] nxt_oh;
   logic [IDX_W-1:0]       nxt_idx;

   // Lowest masked domain at or above the walk index; unmasked indices cost no cycles.
   always_comb begin
      found   = 1'b0;
      nxt_oh  = '0;
      nxt_idx = '0;
      for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
         if (!found && mask_r[i] && (IDX_W'(i) >= idx)) begin
            found     = 1'b1;
            nxt_oh[i] = 1'b1;
            nxt_idx   = IDX_W'(i + 1);
         end
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      mask_n  = mask_r;
      soft_n  = soft_q;
      dom_n   = io_domain_reset;

      case (state)
         S_HOLD: begin
            dom_n = io_domain_reset | mask_r;
            if (cnt == HOLD_LAST) begin
`ifdef RESET_SEQ_PLL_LOCK_EN
               if (!soft_q) begin
                  state_n = S_WAIT_LOCK;
                  cnt_n   = '0;
               end else begin
                  state_n = S_RELEASE;
                  cnt_n   = STAG_LAST;
                  idx_n   = '0;
               end
`else
               state_n = S_RELEASE;
               cnt_n   = STAG_LAST;
               idx_n   = '0;
`endif
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         S_WAIT_LOCK: begin
`ifdef RESET_SEQ_PLL_LOCK_EN
            // cnt counts consecutive lock cycles; any low cycle restarts it.
            if (io_pll_lock) begin
               if (cnt == CNT_W'(1)) begin
                  state_n = S_RELEASE;
                  cnt_n   = STAG_LAST;
                  idx_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end else begin
               cnt_n = '0;
            end
`else
            state_n = S_RELEASE;
            cnt_n   = STAG_LAST;
            idx_n   = '0;
`endif
         end

         S_RELEASE: begin
            if (!found) begin
               state_n = soft_q ? S_ACK : S_IDLE;
            end else if (cnt == STAG_LAST) begin
               dom_n = io_domain_reset & ~nxt_oh;
               idx_n = nxt_idx;
               cnt_n = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         S_IDLE: begin
            if (io_sw_req) begin
               soft_n = 1'b1;
               if (io_sw_mask != '0) begin
                  mask_n  = io_sw_mask;
                  cnt_n   = '0;
                  state_n = S_HOLD;
               end else begin
                  state_n = S_ACK;
               end
            end
         end

         S_ACK: begin
            if (!io_sw_req) state_n = S_IDLE;
         end

         default: state_n = S_HOLD;
      endcase

      busy_n    = (state_n != S_IDLE);
      // An empty-mask request reaches ACK straight from IDLE; ack follows one cycle later.
      ack_n     = (state_n == S_ACK) && (state != S_IDLE);
      all_rel_n = (dom_n == '0) && ((state_n == S_IDLE) || (state_n == S_ACK));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= S_HOLD;
         cnt             <= '0;
         idx             <= '0;
         mask_r          <= '1;
         soft_q          <= 1'b0;
         io_domain_reset <= '1;
         io_busy         <= 1'b1;
         io_sw_ack       <= 1'b0;
         io_all_released <= 1'b0;
      end else begin
         state           <= state_n;
         cnt             <= cnt_n;
         idx             <= idx_n;
         mask_r          <= mask_n;
         soft_q          <= soft_n;
         io_domain_reset <= dom_n;
         io_busy         <= busy_n;
         io_sw_ack       <= ack_n;
         io_all_released <= all_rel_n;
      end
   end

endmodule
